// File: rtl/key_event_counter_pkg.sv
// ============================================================================
// key_event_counter_pkg : shared key polarity, debounce default, event codes
// Rev 1.0
// ============================================================================
`default_nettype none

package key_event_counter_pkg;

  localparam logic KEY_RELEASED     = 1'b1;
  localparam logic KEY_PRESSED      = 1'b0;
  localparam int   DEFAULT_DEBOUNCE = 16;

  // Bit 1 = accepted up press, bit 0 = accepted down press on the same edge
  typedef enum logic [1:0] {
    EV_NONE = 2'b00,
    EV_DOWN = 2'b01,
    EV_UP   = 2'b10,
    EV_BOTH = 2'b11
  } key_event_e;

endpackage

`default_nettype wire

// File: rtl/key_debouncer.sv
// ============================================================================
// key_debouncer : 2-flop synchronizer, stable-count debouncer, press detect
// Rev 1.0
// ============================================================================
`default_nettype none

module key_debouncer
  import key_event_counter_pkg::*;
#(
  parameter int N = DEFAULT_DEBOUNCE
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(N);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;
  logic          accept;

  // press is a strobe for the edge on which level falls; it is decoded from
  // registered state only, so the owner can register its event on that edge.
  assign accept = (s2 != level) && (cnt == CW'(N - 1));
  assign press  = accept && (s2 == KEY_PRESSED);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1    <= KEY_RELEASED;
      s2    <= KEY_RELEASED;
      level <= KEY_RELEASED;
      cnt   <= '0;
    end else begin
      s1 <= key_n;
      s2 <= s1;
      if (s2 == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/key_event_counter.sv
// ============================================================================
// key_event_counter : debounced up/down press counter with wrap strobe
// Rev 1.0
// ============================================================================
`default_nettype none

module key_event_counter
  import key_event_counter_pkg::*;
#(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             key_up_n,
  input  logic             key_down_n,
  output logic [WIDTH-1:0] count,
  output logic             up_pulse,
  output logic             down_pulse,
  output logic             wrap
);

  logic       up_level;
  logic       up_press;
  logic       down_level;
  logic       down_press;
  key_event_e ev;

  key_debouncer #(.N(DEBOUNCE_CYCLES)) u_up_deb (
    .clk   (clk),
    .reset (reset),
    .key_n (key_up_n),
    .level (up_level),
    .press (up_press)
  );

  key_debouncer #(.N(DEBOUNCE_CYCLES)) u_down_deb (
    .clk   (clk),
    .reset (reset),
    .key_n (key_down_n),
    .level (down_level),
    .press (down_press)
  );

  // A press is only ever taken from a released level
  assign ev = key_event_e'({up_press   && (up_level   == KEY_RELEASED),
                            down_press && (down_level == KEY_RELEASED)});

  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      up_pulse   <= 1'b0;
      down_pulse <= 1'b0;
      wrap       <= 1'b0;
    end else begin
      up_pulse   <= ev[1];
      down_pulse <= ev[0];
      wrap       <= 1'b0;
      unique case (ev)
        EV_UP: begin
          count <= count + 1'b1;
          wrap  <= &count;
        end
        EV_DOWN: begin
          count <= count - 1'b1;
          wrap  <= (count == '0);
        end
        EV_NONE, EV_BOTH: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_key_event_counter.sv
// ============================================================================
// tb_key_event_counter : directed and random checks against a history model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_key_event_counter;

  localparam int N     = 4;
  localparam int W     = 4;
  localparam int HMAX  = 8192;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         key_up_n = 1'b1;
  logic         key_down_n = 1'b1;
  logic [W-1:0] count;
  logic         up_pulse;
  logic         down_pulse;
  logic         wrap;

  int checks = 0;
  int failures = 0;

  key_event_counter #(.WIDTH(W), .DEBOUNCE_CYCLES(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .key_up_n   (key_up_n),
    .key_down_n (key_down_n),
    .count      (count),
    .up_pulse   (up_pulse),
    .down_pulse (down_pulse),
    .wrap       (wrap)
  );

  always #5 clk = ~clk;

  // Model: raw key level seen at each edge; a new level is accepted once the
  // synchronized key (two edges late) disagrees for N consecutive edges since
  // the last acceptance or reset.
  bit           hist_up [HMAX];
  bit           hist_dn [HMAX];
  int           nedge = 0;
  bit           lvl_up = 1'b1, lvl_dn = 1'b1;
  int           acc_up = 0, acc_dn = 0;
  logic [W-1:0] m_count = '0;
  logic         m_up = 1'b0, m_dn = 1'b0, m_wrap = 1'b0;

  function automatic bit accepted(input bit dn, input int e);
    bit lvl;
    int last;
    lvl  = dn ? lvl_dn : lvl_up;
    last = dn ? acc_dn : acc_up;
    if (e < last + N || e - N - 1 < 0) return 1'b0;
    for (int i = 2; i <= N + 1; i++) begin
      if ((dn ? hist_dn[e-i] : hist_up[e-i]) == lvl) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic step();
    bit pu, pd, press_u, press_d;
    int e;
    @(posedge clk);
    e = nedge;
    if (reset) begin
      hist_up[e] = 1'b1; hist_dn[e] = 1'b1;
      if (e > 0) begin hist_up[e-1] = 1'b1; hist_dn[e-1] = 1'b1; end
      lvl_up = 1'b1; lvl_dn = 1'b1; acc_up = e; acc_dn = e;
      m_count = '0; m_up = 1'b0; m_dn = 1'b0; m_wrap = 1'b0;
    end else begin
      hist_up[e] = key_up_n; hist_dn[e] = key_down_n;
      pu = accepted(1'b0, e);
      pd = accepted(1'b1, e);
      press_u = pu && lvl_up; press_d = pd && lvl_dn;
      if (pu) begin lvl_up = ~lvl_up; acc_up = e; end
      if (pd) begin lvl_dn = ~lvl_dn; acc_dn = e; end
      m_up = press_u; m_dn = press_d; m_wrap = 1'b0;
      if (press_u && !press_d) begin
        m_wrap  = (int'(m_count) == (1 << W) - 1);
        m_count = W'((int'(m_count) + 1) % (1 << W));
      end else if (press_d && !press_u) begin
        m_wrap  = (m_count == 0);
        m_count = W'((int'(m_count) + (1 << W) - 1) % (1 << W));
      end
    end
    nedge++;
    #1;
  endtask

  task automatic drive(input logic up_n, input logic dn_n, input int cycles,
                       output int mism, output int ups, output int dns, output int wraps);
    key_up_n = up_n; key_down_n = dn_n;
    mism = 0; ups = 0; dns = 0; wraps = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if ({count, up_pulse, down_pulse, wrap} !== {m_count, m_up, m_dn, m_wrap}) mism++;
      ups   += int'(up_pulse);
      dns   += int'(down_pulse);
      wraps += int'(wrap);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; key_up_n = 1'b1; key_down_n = 1'b1;
    repeat (3) step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int mm, u, d, w;
    do_reset();
    checks++;
    if ({count, up_pulse, down_pulse, wrap} !== 7'b0) begin
      failures++;
      $display("FAIL reset_state: got %b expected %b", {count, up_pulse, down_pulse, wrap}, 7'b0);
    end
    drive(1'b1, 1'b1, 20, mm, u, d, w);
    checks++;
    if (mm !== 0 || u !== 0 || d !== 0 || w !== 0 || count !== 4'd0) begin
      failures++;
      $display("FAIL reset_idle: mism=%0d ups=%0d dns=%0d wraps=%0d count=%0d expected all 0", mm, u, d, w, count);
    end
  endtask

  task automatic test_press_latency();
    int first, mm, u, d, w;
    first = -1; mm = 0; u = 0;
    key_up_n = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if ({count, up_pulse, down_pulse, wrap} !== {m_count, m_up, m_dn, m_wrap}) mm++;
      if (up_pulse) begin u++; if (first < 0) first = i; end
    end
    checks++;
    if (first !== N + 1) begin
      failures++;
      $display("FAIL press_latency: pulse edge=%0d expected %0d", first, N + 1);
    end
    checks++;
    if (u !== 1 || count !== 4'd1 || mm !== 0) begin
      failures++;
      $display("FAIL press_single: pulses=%0d count=%0d mism=%0d expected 1,1,0", u, count, mm);
    end
    drive(1'b1, 1'b1, 10, mm, u, d, w);
    checks++;
    if (u !== 0 || d !== 0 || count !== 4'd1 || mm !== 0) begin
      failures++;
      $display("FAIL release_silent: ups=%0d dns=%0d count=%0d mism=%0d expected 0,0,1,0", u, d, count, mm);
    end
  endtask

  task automatic test_glitch();
    int mm, u, d, w, tm, tu;
    tm = 0; tu = 0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 1'b1, N - 1, mm, u, d, w); tm += mm; tu += u + d;
      drive(1'b1, 1'b1, N + 2, mm, u, d, w); tm += mm; tu += u + d;
    end
    checks++;
    if (tu !== 0 || tm !== 0 || count !== 4'd1) begin
      failures++;
      $display("FAIL glitch: pulses=%0d mism=%0d count=%0d expected 0,0,1", tu, tm, count);
    end
  endtask

  task automatic press(input bit dn, output int mm, output int u, output int d, output int w);
    int m2, u2, d2, w2;
    drive(dn, ~dn, N + 3, mm, u, d, w);
    drive(1'b1, 1'b1, N + 3, m2, u2, d2, w2);
    mm += m2; u += u2; d += d2; w += w2;
  endtask

  task automatic test_wrap();
    int mm, u, d, w, tm, tu, tw;
    do_reset();
    tm = 0; tu = 0; tw = 0;
    for (int k = 0; k < 15; k++) begin
      press(1'b0, mm, u, d, w); tm += mm; tu += u; tw += w;
    end
    checks++;
    if (count !== 4'd15 || tu !== 15 || tw !== 0 || tm !== 0) begin
      failures++;
      $display("FAIL up15: count=%0d ups=%0d wraps=%0d mism=%0d expected 15,15,0,0", count, tu, tw, tm);
    end
    press(1'b0, mm, u, d, w);
    checks++;
    if (count !== 4'd0 || u !== 1 || w !== 1 || mm !== 0) begin
      failures++;
      $display("FAIL up_wrap: count=%0d ups=%0d wraps=%0d mism=%0d expected 0,1,1,0", count, u, w, mm);
    end
    press(1'b1, mm, u, d, w);
    checks++;
    if (count !== 4'd15 || d !== 1 || w !== 1 || mm !== 0) begin
      failures++;
      $display("FAIL down_wrap: count=%0d dns=%0d wraps=%0d mism=%0d expected 15,1,1,0", count, d, w, mm);
    end
  endtask

  task automatic test_both();
    int mm, u, d, w, tm, tw;
    tm = 0; tw = 0;
    for (int k = 0; k < 8; k++) begin
      press(1'b0, mm, u, d, w); tm += mm; tw += w;
    end
    checks++;
    if (count !== 4'd7 || tw !== 1 || tm !== 0) begin
      failures++;
      $display("FAIL to_seven: count=%0d wraps=%0d mism=%0d expected 7,1,0", count, tw, tm);
    end
    drive(1'b0, 1'b0, N + 3, mm, u, d, w);
    checks++;
    if (u !== 1 || d !== 1 || w !== 0 || count !== 4'd7 || mm !== 0) begin
      failures++;
      $display("FAIL both: ups=%0d dns=%0d wraps=%0d count=%0d mism=%0d expected 1,1,0,7,0", u, d, w, count, mm);
    end
    drive(1'b1, 1'b1, N + 3, mm, u, d, w);
  endtask

  task automatic test_reset_mid_debounce();
    int first, bad, mm, dp, wr;
    do_reset();
    key_down_n = 1'b0;
    repeat (2) step();
    reset = 1'b1; bad = 0;
    repeat (2) begin
      step();
      if (count !== 4'd0 || up_pulse || down_pulse || wrap) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++;
      $display("FAIL reset_hold: bad_cycles=%0d expected 0", bad);
    end
    reset = 1'b0; first = -1; mm = 0; dp = 0; wr = 0;
    for (int i = 0; i < N + 4; i++) begin
      step();
      if ({count, up_pulse, down_pulse, wrap} !== {m_count, m_up, m_dn, m_wrap}) mm++;
      if (down_pulse) begin dp++; if (first < 0) first = i; end
      wr += int'(wrap);
    end
    checks++;
    if (first !== N + 1 || dp !== 1 || wr !== 1 || count !== 4'd15 || mm !== 0) begin
      failures++;
      $display("FAIL post_reset_press: edge=%0d pulses=%0d wraps=%0d count=%0d mism=%0d expected %0d,1,1,15,0",
               first, dp, wr, count, mm, N + 1);
    end
    key_down_n = 1'b1;
    repeat (N + 3) step();
  endtask

  task automatic test_random();
    int hold, mm;
    mm = 0;
    for (int seg = 0; seg < 300; seg++) begin
      key_up_n   = 1'($urandom_range(0, 1));
      key_down_n = 1'($urandom_range(0, 1));
      reset      = ($urandom_range(0, 39) == 0);
      hold       = reset ? 1 : $urandom_range(1, 2 * N + 2);
      for (int i = 0; i < hold; i++) begin
        step();
        checks++;
        if ({count, up_pulse, down_pulse, wrap} !== {m_count, m_up, m_dn, m_wrap}) begin
          failures++; mm++;
          if (mm <= 10)
            $display("FAIL random: cnt/up/dn/wrap got %0d/%b/%b/%b expected %0d/%b/%b/%b",
                     count, up_pulse, down_pulse, wrap, m_count, m_up, m_dn, m_wrap);
        end
      end
      reset = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_press_latency();
    test_glitch();
    test_wrap();
    test_both();
    test_reset_mid_debounce();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
